// File: rtl/simple_uart_transmitter.sv
`default_nettype none
// ============================================================================
// simple_uart_transmitter : 8N1 UART transmitter fed by a 2^FIFO_AW byte FIFO
// Revision 1.0 - initial release
// ============================================================================
module simple_uart_transmitter #(
    parameter int CLKS_PER_BIT = 2170,
    parameter int FIFO_AW      = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_dat,
    input  logic               i_dat_vld,
    output logic               o_rdy,
    output logic               o_tx,
    output logic               o_busy,
    output logic [FIFO_AW:0]   o_level
);

    localparam int                DEPTH    = 1 << FIFO_AW;
    localparam int                CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]  LVL_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and pointers (MSB of each pointer separates full from empty)
    logic [7:0]       mem_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
    logic             rdy_q, rdy_d;

    // Transmit engine
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             launch_q, launch_d;

    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic             wrap;
    logic [CW-1:0]    cnt_inc;
    logic [FIFO_AW:0] level;
    logic [FIFO_AW:0] level_nxt;
    logic [7:0]       head;

    assign push      = i_dat_vld && rdy_q;
    assign level     = wr_ptr_q - rd_ptr_q;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (level == LVL_FULL);
    assign head      = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign wrap      = (cnt_q == CNT_LAST);
    assign cnt_inc   = wrap ? '0 : cnt_q + 1'b1;

    assign wr_ptr_d  = wr_ptr_q + (FIFO_AW + 1)'(push);
    assign rd_ptr_d  = rd_ptr_q + (FIFO_AW + 1)'(pop);
    assign level_nxt = wr_ptr_d - rd_ptr_d;
    // Falls on the edge that fills the FIFO, rises one edge after it stops being full
    assign rdy_d     = !full && (level_nxt != LVL_FULL);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        launch_d = launch_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                // Pop first, start the frame on the following edge
                if (launch_q) begin
                    state_d  = START;
                    tx_d     = 1'b0;
                    launch_d = 1'b0;
                end else if (!empty) begin
                    pop      = 1'b1;
                    shift_d  = head;
                    launch_d = 1'b1;
                end
            end
            START: begin
                cnt_d = cnt_inc;
                if (wrap) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                cnt_d = cnt_inc;
                if (wrap) begin
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP: begin
                cnt_d = cnt_inc;
                if (wrap) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            launch_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            launch_q <= launch_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdy_q    <= rdy_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= i_dat;
        end
    end

    assign o_rdy   = rdy_q;
    assign o_tx    = tx_q;
    assign o_busy  = (state_q != IDLE);
    assign o_level = level;

endmodule
`default_nettype wire

// File: tb/tb_simple_uart_transmitter.sv
`default_nettype none
// ============================================================================
// tb_simple_uart_transmitter : directed self-checking bench, CLKS_PER_BIT=4, FIFO_AW=2
// Revision 1.0 - initial release
// ============================================================================
module tb_simple_uart_transmitter;

    localparam int CPB = 4;
    localparam int AW  = 2;

    logic          clk       = 1'b0;
    logic          i_rst     = 1'b1;
    logic [7:0]    i_dat     = 8'h00;
    logic          i_dat_vld = 1'b0;
    logic          o_rdy;
    logic          o_tx;
    logic          o_busy;
    logic [AW:0]   o_level;

    int n_vec = 0;
    int n_err = 0;

    simple_uart_transmitter #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_dat     (i_dat),
        .i_dat_vld (i_dat_vld),
        .o_rdy     (o_rdy),
        .o_tx      (o_tx),
        .o_busy    (o_busy),
        .o_level   (o_level)
    );

    always #5 clk = ~clk;

    // Independent serial decoder: mid-bit sampling counted from the start-bit edge
    logic [7:0] rx_buf [0:63];
    logic [7:0] rx_sh   = 8'h00;
    int         rx_n    = 0;
    int         rx_cnt  = 0;
    int         rx_ferr = 0;
    logic       rx_busy = 1'b0;

    always @(negedge clk) begin
        if (i_rst) begin
            rx_busy <= 1'b0;
        end else if (!rx_busy) begin
            if (o_tx === 1'b0) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if ((rx_cnt % CPB) == 2 && rx_cnt >= 6 && rx_cnt <= 34)
                rx_sh <= {o_tx, rx_sh[7:1]};
            if (rx_cnt == 38) begin
                if (o_tx !== 1'b1) rx_ferr <= rx_ferr + 1;
                rx_buf[rx_n] <= rx_sh;
                rx_n         <= rx_n + 1;
            end
            if (rx_cnt == 39) rx_busy <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one 40-cycle frame starting at the current sample point
    task automatic check_frame(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int j = 0; j < 10 * CPB; j++) begin
            chk($sformatf("frame_%02h_tx_c%0d", b, j), 32'(o_tx), 32'(fr[j / CPB]));
            chk($sformatf("frame_%02h_busy_c%0d", b, j), 32'(o_busy), 32'd1);
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   np;
        int   base;
        int   saw_full;
        int   bad_tx;
        int   bad_busy;
        logic acc;

        // ---- reset ----
        i_rst = 1'b1;
        tick();
        tick();
        chk("rst_tx", 32'(o_tx), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_rdy", 32'(o_rdy), 32'd0);
        i_rst = 1'b0;
        tick();
        chk("rdy_after_rst", 32'(o_rdy), 32'd1);

        // ---- single byte 0xA5 ----
        i_dat = 8'hA5; i_dat_vld = 1'b1;
        tick();
        i_dat_vld = 1'b0;
        chk("single_level_k", 32'(o_level), 32'd1);
        chk("single_tx_k", 32'(o_tx), 32'd1);
        chk("single_busy_k", 32'(o_busy), 32'd0);
        tick();
        chk("single_tx_k1", 32'(o_tx), 32'd1);
        chk("single_busy_k1", 32'(o_busy), 32'd0);
        tick();
        check_frame(8'hA5);
        chk("single_busy_end", 32'(o_busy), 32'd0);
        chk("single_level_end", 32'(o_level), 32'd0);
        chk("single_tx_end", 32'(o_tx), 32'd1);
        chk("single_rx_n", 32'(rx_n), 32'd1);
        chk("single_rx_byte", 32'(rx_buf[0]), 32'hA5);

        // ---- burst 0x00, 0xFF, 0x55 ----
        i_dat = 8'h00; i_dat_vld = 1'b1;
        tick();
        chk("burst_level_1", 32'(o_level), 32'd1);
        i_dat = 8'hFF;
        tick();
        i_dat = 8'h55;
        tick();
        i_dat_vld = 1'b0;
        chk("burst_level_3", 32'(o_level), 32'd2);
        check_frame(8'h00);
        chk("burst_level_f1", 32'(o_level), 32'd1);
        check_frame(8'hFF);
        chk("burst_level_f2", 32'(o_level), 32'd0);
        check_frame(8'h55);
        chk("burst_busy_end", 32'(o_busy), 32'd0);
        chk("burst_rx_n", 32'(rx_n), 32'd4);
        chk("burst_rx_0", 32'(rx_buf[1]), 32'h00);
        chk("burst_rx_1", 32'(rx_buf[2]), 32'hFF);
        chk("burst_rx_2", 32'(rx_buf[3]), 32'h55);

        // ---- reset during D3 of 0xC3 with two bytes queued ----
        i_dat = 8'hC3; i_dat_vld = 1'b1;
        tick();
        i_dat = 8'hAA;
        tick();
        i_dat = 8'h11;
        tick();
        i_dat_vld = 1'b0;
        chk("rstmid_level", 32'(o_level), 32'd2);
        for (int j = 0; j < 17; j++) tick();
        chk("rstmid_in_frame", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        tick();
        chk("rstmid_tx", 32'(o_tx), 32'd1);
        chk("rstmid_busy", 32'(o_busy), 32'd0);
        chk("rstmid_level0", 32'(o_level), 32'd0);
        chk("rstmid_rdy", 32'(o_rdy), 32'd0);
        i_rst = 1'b0;
        tick();
        chk("rstmid_rdy_rel", 32'(o_rdy), 32'd1);
        bad_tx = 0; bad_busy = 0;
        for (int j = 0; j < 60; j++) begin
            if (o_tx !== 1'b1) bad_tx++;
            if (o_busy !== 1'b0) bad_busy++;
            tick();
        end
        chk("rstmid_quiet_tx", 32'(bad_tx), 32'd0);
        chk("rstmid_quiet_busy", 32'(bad_busy), 32'd0);
        chk("rstmid_rx_n", 32'(rx_n), 32'd4);
        i_dat = 8'h3C; i_dat_vld = 1'b1;
        tick();
        i_dat_vld = 1'b0;
        tick();
        tick();
        check_frame(8'h3C);
        chk("rstmid_new_busy", 32'(o_busy), 32'd0);
        chk("rstmid_new_rx_n", 32'(rx_n), 32'd5);
        chk("rstmid_new_rx", 32'(rx_buf[4]), 32'h3C);

        // ---- full FIFO with vld held high ----
        base = rx_n;
        np = 0;
        saw_full = 0;
        for (int t = 0; t < 200; t++) begin
            i_dat = 8'h10 + 8'(np);
            i_dat_vld = 1'b1;
            acc = o_rdy;
            tick();
            if (acc) np++;
            if (o_level == 3'd4) begin
                saw_full = 1;
                chk("full_rdy_low", 32'(o_rdy), 32'd0);
            end
            chk("full_level_max", 32'(o_level <= 3'd4), 32'd1);
        end
        i_dat_vld = 1'b0;
        chk("full_reached", 32'(saw_full), 32'd1);
        for (int t = 0; t < 400 && (o_busy || o_level != 0); t++) tick();
        for (int t = 0; t < 45; t++) tick();
        chk("full_drained_busy", 32'(o_busy), 32'd0);
        chk("full_drained_level", 32'(o_level), 32'd0);
        chk("full_rx_count", 32'(rx_n - base), 32'(np));
        for (int i = 0; i < np; i++)
            chk($sformatf("full_rx_order_%0d", i), 32'(rx_buf[base + i]), 32'(8'h10 + 8'(i)));
        chk("rx_stop_bits", 32'(rx_ferr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
